// File: rtl/nios_system_led_ctrl.sv
// Avalon-MM LED/output-port controller: DATA, atomic set/clear and a per-bit
// blink engine driven by a programmable half-period counter.
module nios_system_led_ctrl #(
  parameter int unsigned      WIDTH          = 8,
  parameter int unsigned      CNT_WIDTH      = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
  parameter logic [31:0]      DEFAULT_PERIOD = 32'd2499999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_BLINK  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_WIDTH-1:0] PERIOD_INIT = DEFAULT_PERIOD[CNT_WIDTH-1:0];

  logic [WIDTH-1:0]     r_data;
  logic [WIDTH-1:0]     r_blink_en;
  logic [CNT_WIDTH-1:0] r_period;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_phase;
  logic [WIDTH-1:0]     r_out;

  logic                 w_wr;
  logic                 w_period_wr;
  logic [WIDTH-1:0]     w_wd;
  logic [CNT_WIDTH-1:0] w_wd_cnt;
  logic [WIDTH-1:0]     w_out_next;
  logic [31:0]          w_rd;
  logic                 w_unused_wd;

  assign w_wr        = chipselect & ~write_n;
  assign w_period_wr = w_wr && (address == ADDR_PERIOD);
  assign w_wd        = writedata[WIDTH-1:0];
  assign w_wd_cnt    = writedata[CNT_WIDTH-1:0];
  assign w_unused_wd = ^writedata;

  // Register file writes; OUTSET/OUTCLR are read-modify-write of DATA.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data     <= RESET_VALUE;
      r_blink_en <= '0;
      r_period   <= PERIOD_INIT;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:   r_data     <= w_wd;
        ADDR_BLINK:  r_blink_en <= w_wd;
        ADDR_PERIOD: r_period   <= w_wd_cnt;
        ADDR_OUTSET: r_data     <= r_data | w_wd;
        ADDR_OUTCLR: r_data     <= r_data & ~w_wd;
        default:     r_data     <= r_data;
      endcase
    end else begin
      r_data <= r_data;
    end
  end

  // Blink engine; a PERIOD write restarts the count and wins over a reload.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt   <= PERIOD_INIT;
      r_phase <= 1'b1;
    end else if (w_period_wr) begin
      r_cnt   <= w_wd_cnt;
      r_phase <= 1'b1;
    end else if (r_cnt == CNT_ZERO) begin
      r_cnt   <= r_period;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt - CNT_ONE;
    end
  end

  // Blinking bits are masked off during the low phase.
  always_comb begin
    w_out_next = r_data & ~(r_blink_en & {WIDTH{~r_phase}});
  end

  // Registered output pins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out <= RESET_VALUE;
    end else begin
      r_out <= w_out_next;
    end
  end

  assign out_port = r_out;

  // Combinational, zero-extended read mux; no read side effects.
  always_comb begin
    w_rd = 32'd0;
    case (address)
      ADDR_DATA:   w_rd[WIDTH-1:0]     = r_data;
      ADDR_BLINK:  w_rd[WIDTH-1:0]     = r_blink_en;
      ADDR_PERIOD: w_rd[CNT_WIDTH-1:0] = r_period;
      ADDR_STATUS: w_rd[0]             = r_phase;
      default:     w_rd                = 32'd0;
    endcase
  end

  assign readdata = w_rd;

endmodule

// File: tb/tb_nios_system_led_ctrl.sv
// Directed bench: a default-width instance (RESET_VALUE=A5) and a
// WIDTH=32 / CNT_WIDTH=4 instance sharing clock, reset and bus lines.
module tb_nios_system_led_ctrl;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        cs0, cs1;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rd0, rd1;
  logic [7:0]  out0;
  logic [31:0] out1;

  int n_checks = 0;
  int n_errors = 0;

  nios_system_led_ctrl #(
    .WIDTH(8), .CNT_WIDTH(24), .RESET_VALUE(8'hA5), .DEFAULT_PERIOD(32'd2499999)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .out_port(out0)
  );

  nios_system_led_ctrl #(
    .WIDTH(32), .CNT_WIDTH(4), .RESET_VALUE(32'h1234_5678), .DEFAULT_PERIOD(32'd5)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .out_port(out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  rd_addr;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs [0:12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic sel, input logic [2:0] a, input logic [31:0] d);
    cs0 = ~sel;
    cs1 = sel;
    write_n = 1'b0;
    address = a;
    writedata = d;
    step();
    cs0 = 1'b0;
    cs1 = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd_check(input logic sel, input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, sel ? rd1 : rd0, exp);
  endtask

  initial begin
    // wr, addr, wdata, rd_addr, exp_rd, exp_out (out lags the write by one edge)
    vecs[0]  = '{1'b0, 3'd0, 32'h0000_0000, 3'd0, 32'h0000_00A5, 8'hA5};
    vecs[1]  = '{1'b1, 3'd0, 32'hFFFF_FF0F, 3'd0, 32'h0000_000F, 8'hA5};
    vecs[2]  = '{1'b1, 3'd4, 32'h0000_00C0, 3'd0, 32'h0000_00CF, 8'h0F};
    vecs[3]  = '{1'b1, 3'd5, 32'h0000_0003, 3'd0, 32'h0000_00CC, 8'hCF};
    vecs[4]  = '{1'b0, 3'd0, 32'h0000_0000, 3'd4, 32'h0000_0000, 8'hCC};
    vecs[5]  = '{1'b0, 3'd0, 32'h0000_0000, 3'd5, 32'h0000_0000, 8'hCC};
    vecs[6]  = '{1'b1, 3'd3, 32'h0000_0000, 3'd3, 32'h0000_0001, 8'hCC};
    vecs[7]  = '{1'b1, 3'd6, 32'hFFFF_FFFF, 3'd6, 32'h0000_0000, 8'hCC};
    vecs[8]  = '{1'b1, 3'd7, 32'h0000_0000, 3'd0, 32'h0000_00CC, 8'hCC};
    vecs[9]  = '{1'b1, 3'd1, 32'h0000_01F0, 3'd1, 32'h0000_00F0, 8'hCC};
    vecs[10] = '{1'b0, 3'd0, 32'h0000_0000, 3'd0, 32'h0000_00CC, 8'hCC};
    vecs[11] = '{1'b1, 3'd1, 32'h0000_0000, 3'd1, 32'h0000_0000, 8'hCC};
    vecs[12] = '{1'b1, 3'd2, 32'hFF00_0003, 3'd2, 32'h0000_0003, 8'hCC};

    reset_n = 1'b0;
    cs0 = 1'b0;
    cs1 = 1'b0;
    write_n = 1'b1;
    address = 3'd0;
    writedata = 32'd0;
    step();
    step();
    reset_n = 1'b1;

    check("reset_out", {24'd0, out0}, 32'h0000_00A5);
    rd_check(1'b0, "reset_data", 3'd0, 32'h0000_00A5);
    rd_check(1'b0, "reset_blink", 3'd1, 32'h0000_0000);
    rd_check(1'b0, "reset_period", 3'd2, 32'd2499999);
    rd_check(1'b0, "reset_status", 3'd3, 32'h0000_0001);

    for (int i = 0; i <= 12; i++) begin
      cs0 = vecs[i].wr;
      write_n = ~vecs[i].wr;
      address = vecs[i].addr;
      writedata = vecs[i].wdata;
      step();
      cs0 = 1'b0;
      write_n = 1'b1;
      address = vecs[i].rd_addr;
      #1;
      check($sformatf("vec%0d_rd", i), rd0, vecs[i].exp_rd);
      check($sformatf("vec%0d_out", i), {24'd0, out0}, {24'd0, vecs[i].exp_out});
    end

    // PERIOD=3 blink on bit 0: four cycles high, four low, bits 7:1 at zero.
    bus_wr(1'b0, 3'd0, 32'h0000_0001);
    bus_wr(1'b0, 3'd1, 32'h0000_0001);
    bus_wr(1'b0, 3'd2, 32'h0000_0003);
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("blink3_k%0d", k), {24'd0, out0}, (((k - 1) / 4) % 2 == 0) ? 32'd1 : 32'd0);
    end

    // PERIOD=0 toggles every cycle.
    bus_wr(1'b0, 3'd2, 32'h0000_0000);
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("blink0_k%0d", k), {24'd0, out0}, (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    // PERIOD=9 written while cnt==0: phase forced high, next toggle 10 edges later.
    bus_wr(1'b0, 3'd2, 32'h0000_0009);
    rd_check(1'b0, "p9_status_k7", 3'd3, 32'd1);
    check("p9_out_k7", {24'd0, out0}, 32'd1);
    for (int k = 8; k <= 18; k++) begin
      step();
      rd_check(1'b0, $sformatf("p9_status_k%0d", k), 3'd3, (k <= 16) ? 32'd1 : 32'd0);
      check($sformatf("p9_out_k%0d", k), {24'd0, out0}, (k <= 17) ? 32'd1 : 32'd0);
    end

    // Reset mid-blink with a simultaneous DATA write: write dropped.
    reset_n = 1'b0;
    cs0 = 1'b1;
    write_n = 1'b0;
    address = 3'd0;
    writedata = 32'h0000_00FF;
    step();
    reset_n = 1'b1;
    cs0 = 1'b0;
    write_n = 1'b1;
    check("rst2_out", {24'd0, out0}, 32'h0000_00A5);
    rd_check(1'b0, "rst2_data", 3'd0, 32'h0000_00A5);
    rd_check(1'b0, "rst2_blink", 3'd1, 32'h0000_0000);
    rd_check(1'b0, "rst2_period", 3'd2, 32'd2499999);
    rd_check(1'b0, "rst2_status", 3'd3, 32'd1);
    step();
    check("rst2_out_hold", {24'd0, out0}, 32'h0000_00A5);

    // Wide instance: 32-bit DATA, PERIOD truncated to 4 bits.
    check("w32_reset_out", out1, 32'h1234_5678);
    rd_check(1'b1, "w32_reset_data", 3'd0, 32'h1234_5678);
    rd_check(1'b1, "w32_reset_period", 3'd2, 32'd5);
    bus_wr(1'b1, 3'd2, 32'hFFFF_FFF2);
    rd_check(1'b1, "w32_period_trunc", 3'd2, 32'd2);
    bus_wr(1'b1, 3'd0, 32'hDEAD_BEEF);
    rd_check(1'b1, "w32_data", 3'd0, 32'hDEAD_BEEF);
    bus_wr(1'b1, 3'd1, 32'hFFFF_FFFF);
    rd_check(1'b1, "w32_blink", 3'd1, 32'hFFFF_FFFF);
    bus_wr(1'b1, 3'd2, 32'hFFFF_FFF2);
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("w32_blink_k%0d", k), out1, (((k - 1) / 3) % 2 == 0) ? 32'hDEAD_BEEF : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
